// File: rtl/evm_ballot_unit.sv
// Voter-side ballot panel: arms on a ballot issue, debounces one button, emits one
// fixed-width candidate pulse, then locks out until hold-off expires and buttons are released.
`timescale 1ns/1ps
module evm_ballot_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ballot_issue,
  input  logic        btn_1,
  input  logic        btn_2,
  input  logic        btn_3,
  input  logic        voting_over,
  output logic        candidate_1,
  output logic        candidate_2,
  output logic        candidate_3,
  output logic        ballot_ready,
  output logic        vote_done,
  output logic        invalid_press,
  output logic [15:0] votes_cast
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DEBOUNCE, S_PULSE, S_HOLDOFF, S_CLOSED
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] PL_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] HO_LAST = 8'(HOLDOFF_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  sync1_q, sync1_d;
  logic [2:0]  sync2_q, sync2_d;
  logic [2:0]  pat_prev_q, pat_prev_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  cand_q, cand_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        inv_q, inv_d;
  logic [15:0] votes_q, votes_d;
  logic [2:0]  pat;

  function automatic logic is_multi(input logic [2:0] p);
    return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
  endfunction

  function automatic logic is_onehot(input logic [2:0] p);
    return (p != 3'b000) && !is_multi(p);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pat = sync2_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    sync1_d    = {btn_3, btn_2, btn_1};
    sync2_d    = sync1_q;
    pat_prev_d = pat;
    done_d     = 1'b0;
    votes_d    = votes_q;
    // Only the transition into a multi-hot pattern is flagged, not every cycle it persists.
    inv_d      = ((state_q == S_ARMED) || (state_q == S_DEBOUNCE)) && !voting_over &&
                 is_multi(pat) && !is_multi(pat_prev_q);

    if (voting_over) begin
      state_d = S_CLOSED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ballot_issue && (pat == 3'b000)) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (is_onehot(pat)) begin
            sel_d = pat;
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = S_PULSE;
              cnt_d   = '0;
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = 8'd1;
            end
          end
        end
        S_DEBOUNCE: begin
          if (pat != sel_q) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = S_PULSE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_PULSE: begin
          if (cnt_q == PL_LAST) begin
            state_d = S_HOLDOFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_HOLDOFF: begin
          // Count parks at its last value so a held button stretches the lockout.
          if (cnt_q != HO_LAST) begin
            cnt_d = cnt_q + 8'd1;
          end else if (pat == 3'b000) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            votes_d = sat_inc(votes_q);
          end
        end
        S_CLOSED: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    cand_d  = (state_d == S_PULSE) ? sel_d : 3'b000;
    ready_d = (state_d == S_ARMED) || (state_d == S_DEBOUNCE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      pat_prev_q <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      cand_q     <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      inv_q      <= 1'b0;
      votes_q    <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      pat_prev_q <= pat_prev_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      inv_q      <= inv_d;
      votes_q    <= votes_d;
    end
  end

  assign candidate_1   = cand_q[0];
  assign candidate_2   = cand_q[1];
  assign candidate_3   = cand_q[2];
  assign ballot_ready  = ready_q;
  assign vote_done     = done_q;
  assign invalid_press = inv_q;
  assign votes_cast    = votes_q;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Bench for evm_ballot_unit: a procedural ballot-story model checked every cycle,
// plus literal expectations on timing, pulse counts and vote totals.
`timescale 1ns/1ps
module tb_evm_ballot_unit;
  localparam int D = 8;
  localparam int P = 4;
  localparam int H = 24;

  logic clk = 1'b0, rst = 1'b0, ballot_issue = 1'b0, voting_over = 1'b0;
  logic btn_1 = 1'b0, btn_2 = 1'b0, btn_3 = 1'b0;
  logic candidate_1, candidate_2, candidate_3, ballot_ready, vote_done, invalid_press;
  logic [15:0] votes_cast;

  evm_ballot_unit #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .ballot_issue(ballot_issue),
    .btn_1(btn_1), .btn_2(btn_2), .btn_3(btn_3), .voting_over(voting_over),
    .candidate_1(candidate_1), .candidate_2(candidate_2), .candidate_3(candidate_3),
    .ballot_ready(ballot_ready), .vote_done(vote_done), .invalid_press(invalid_press),
    .votes_cast(votes_cast)
  );

  always #5 clk = ~clk;

  int cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  int n_cmp = 0, n_bad = 0;
  int np[3];
  int ndone, ninv, rise_cyc, fall_cyc, done_cyc, k, r;

  // Model state: expected outputs plus the story's view of the last sampled edge.
  logic [2:0]  m_s1 = '0, m_s2 = '0, m_last = '0;
  logic [2:0]  exp_cand = '0;
  logic        exp_ready = 1'b0, exp_done = 1'b0, exp_inv = 1'b0;
  logic [15:0] m_votes = '0;
  logic [2:0]  t_pat = '0, t_prev = '0;
  logic        t_issue = 1'b0;
  bit          m_abort = 1'b0, m_rst = 1'b1;

  task automatic tick();
    @(posedge clk or negedge rst);
    exp_done = 1'b0;
    exp_inv  = 1'b0;
    if (!rst) begin
      m_rst = 1'b1; m_abort = 1'b0;
      m_s1 = '0; m_s2 = '0; m_last = '0; t_pat = '0; t_prev = '0; t_issue = 1'b0;
      exp_cand = '0; exp_ready = 1'b0; m_votes = '0;
      return;
    end
    t_pat   = m_s2;
    t_prev  = m_last;
    m_last  = m_s2;
    m_s2    = m_s1;
    m_s1    = {btn_3, btn_2, btn_1};
    t_issue = ballot_issue;
    m_abort = voting_over;
    if (m_abort) begin
      exp_cand  = '0;
      exp_ready = 1'b0;
    end
  endtask

  task automatic model_run();
    logic [2:0] sel;
    int run, n;
    forever begin
      if (m_rst) begin
        wait (rst === 1'b1);
        m_rst = 1'b0;
      end else if (m_abort) begin
        do tick(); while (m_abort && !m_rst);
      end else begin
        do tick(); while (!m_rst && !m_abort && !(t_issue && t_pat == 3'b000));
        if (m_rst || m_abort) continue;
        exp_ready = 1'b1;
        sel = '0;
        run = 0;
        while (run < D) begin
          tick();
          if (m_rst || m_abort) break;
          exp_inv = ($countones(t_pat) > 1) && ($countones(t_prev) < 2);
          if (sel != 3'b000) begin
            if (t_pat == sel) run++;
            else begin sel = '0; run = 0; end
          end else if ($onehot(t_pat)) begin
            sel = t_pat;
            run = 1;
          end
        end
        if (m_rst || m_abort) continue;
        exp_ready = 1'b0;
        exp_cand  = sel;
        for (int i = 0; i < P; i++) begin
          tick();
          if (m_rst || m_abort) break;
        end
        if (m_rst || m_abort) continue;
        exp_cand = '0;
        n = 0;
        do begin tick(); n++; end
        while (!m_rst && !m_abort && !(n >= H && t_pat == 3'b000));
        if (m_rst || m_abort) continue;
        exp_done = 1'b1;
        if (m_votes != 16'hFFFF) m_votes++;
      end
    end
  endtask

  task automatic compare_loop();
    logic [2:0] c, pc;
    pc = '0;
    forever begin
      @(negedge clk);
      n_cmp++;
      if ({candidate_3, candidate_2, candidate_1, ballot_ready, vote_done, invalid_press, votes_cast}
          !== {exp_cand, exp_ready, exp_done, exp_inv, m_votes}) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: got cand=%b rdy=%b done=%b inv=%b votes=%h, want cand=%b rdy=%b done=%b inv=%b votes=%h",
                 cyc_no, {candidate_3, candidate_2, candidate_1}, ballot_ready, vote_done,
                 invalid_press, votes_cast, exp_cand, exp_ready, exp_done, exp_inv, m_votes);
      end
      c = {candidate_3, candidate_2, candidate_1};
      for (int i = 0; i < 3; i++) if (c[i] && !pc[i]) np[i]++;
      if (c != 3'b000 && pc == 3'b000) rise_cyc = cyc_no;
      if (c == 3'b000 && pc != 3'b000) fall_cyc = cyc_no;
      pc = c;
      if (vote_done) begin ndone++; done_cyc = cyc_no; end
      if (invalid_press) ninv++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic issue();
    ballot_issue = 1'b1;
    cyc(1);
    ballot_issue = 1'b0;
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) np[i] = 0;
    ndone = 0; ninv = 0; rise_cyc = -1000; fall_cyc = -2000; done_cyc = -3000;
  endtask

  initial begin
    clr();
    fork
      model_run();
      compare_loop();
    join_none
    cyc(3);
    check("reset_votes", 32'(votes_cast), 0);
    check("reset_ready", 32'(ballot_ready), 0);
    rst = 1'b1;
    cyc(2);

    // Basic vote on candidate 2
    clr(); issue(); cyc(2);
    btn_2 = 1'b1; k = cyc_no; cyc(20); btn_2 = 1'b0; cyc(30);
    check("basic_rise_offset", rise_cyc - k, 10);
    check("basic_width", fall_cyc - rise_cyc, 4);
    check("basic_c2_pulses", np[1], 1);
    check("basic_other_pulses", np[0] + np[2], 0);
    check("basic_done_count", ndone, 1);
    check("basic_done_offset", done_cyc - k, 38);
    check("basic_votes", 32'(votes_cast), 1);

    // Bounce rejection on candidate 1
    clr(); issue(); cyc(2);
    repeat (10) begin btn_1 = 1'b1; cyc(2); btn_1 = 1'b0; cyc(1); end
    check("bounce_quiet", np[0] + np[1] + np[2], 0);
    btn_1 = 1'b1; k = cyc_no; cyc(20); btn_1 = 1'b0; cyc(30);
    check("bounce_rise_offset", rise_cyc - k, 10);
    check("bounce_c1_pulses", np[0], 1);
    check("bounce_votes", 32'(votes_cast), 2);

    // Multi-press, then release one button
    clr(); issue(); cyc(2);
    btn_1 = 1'b1; btn_3 = 1'b1; cyc(12);
    check("multi_no_pulse", np[0] + np[1] + np[2], 0);
    check("multi_invalid", ninv, 1);
    btn_3 = 1'b0; k = cyc_no; cyc(20); btn_1 = 1'b0; cyc(30);
    check("multi_invalid_once", ninv, 1);
    check("multi_c1_pulses", np[0], 1);
    check("multi_c3_pulses", np[2], 0);
    check("multi_rise_offset", rise_cyc - k, 10);
    check("multi_votes", 32'(votes_cast), 3);

    // No ballot issued; issue while a button is held
    clr(); btn_1 = 1'b1; cyc(20); btn_1 = 1'b0; cyc(5);
    btn_2 = 1'b1; cyc(3); issue(); cyc(3); btn_2 = 1'b0; cyc(5);
    check("noballot_pulses", np[0] + np[1] + np[2], 0);
    check("issue_held_ignored", 32'(ballot_ready), 0);
    check("noballot_votes", 32'(votes_cast), 3);

    // Button held long after the pulse
    clr(); issue(); cyc(2);
    btn_1 = 1'b1; k = cyc_no; cyc(14 + 100); r = cyc_no; btn_1 = 1'b0; cyc(10);
    check("held_fall_offset", fall_cyc - k, 14);
    check("held_done_after_release", done_cyc - r, 3);
    check("held_done_count", ndone, 1);
    check("held_votes", 32'(votes_cast), 4);

    // Close of poll during the second pulse cycle
    clr(); issue(); cyc(2);
    btn_3 = 1'b1; k = cyc_no; cyc(11); voting_over = 1'b1; cyc(1);
    check("close_cand_off", 32'(candidate_3), 0);
    check("close_width", fall_cyc - rise_cyc, 2);
    issue(); cyc(3);
    check("close_issue_ignored", 32'(ballot_ready), 0);
    btn_3 = 1'b0; cyc(5); voting_over = 1'b0; cyc(3);
    check("close_votes", 32'(votes_cast), 4);
    check("close_done_count", ndone, 0);
    issue(); cyc(2);
    check("reopen_ready", 32'(ballot_ready), 1);

    // Asynchronous reset during hold-off
    clr(); btn_2 = 1'b1; cyc(16); btn_2 = 1'b0; cyc(4);
    check("rst_pre_pulse", np[1], 1);
    #2 rst = 1'b0;
    #1;
    check("rst_votes", 32'(votes_cast), 0);
    check("rst_cands", 32'({candidate_3, candidate_2, candidate_1}), 0);
    check("rst_flags", 32'({ballot_ready, vote_done, invalid_press}), 0);
    cyc(2); rst = 1'b1; cyc(2);
    issue(); cyc(2);
    check("rst_rearm_ready", 32'(ballot_ready), 1);

    // Saturation of the vote counter
    force dut.votes_q = 16'hFFFF;
    m_votes = 16'hFFFF;
    cyc(2);
    release dut.votes_q;
    cyc(1);
    check("sat_preload", 32'(votes_cast), 32'hFFFF);
    clr(); btn_1 = 1'b1; cyc(20); btn_1 = 1'b0; cyc(30);
    check("sat_done_count", ndone, 1);
    check("sat_c1_pulses", np[0], 1);
    check("sat_votes", 32'(votes_cast), 32'hFFFF);

    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/evm_ballot_unit.md
# evm_ballot_unit

Voter-side ballot unit that sits in front of the vote-counting unit and drives its `candidate_1..3` inputs. It accepts one ballot authorisation from the presiding officer and debounces the voter's raw button. It then emits exactly one clean, fixed-width high pulse on the chosen candidate line, whose falling edge the counter registers. A hold-off then locks the panel until the next ballot is issued.

## Interface
- `DEBOUNCE_CYCLES`, default 8: consecutive synchronized samples of a single button required to accept a vote; legal range 1..255.
- `PULSE_CYCLES`, default 4: width of the candidate pulse in clocks; legal range 1..255.
- `HOLDOFF_CYCLES`, default 24: minimum low time after the pulse; legal range 18..255, which covers the counter's 16-cycle check window.

- `clk` input, 1 bit: single clock; all logic on posedge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `ballot_issue` input, 1 bit: presiding-officer enable, sampled synchronously.
- `btn_1`, `btn_2`, `btn_3` input, 1 bit each: raw, asynchronous voter buttons, active high.
- `voting_over` input, 1 bit: close of poll; same signal as the counter's `i_voting_over`.
- `candidate_1`, `candidate_2`, `candidate_3` output, 1 bit each: registered vote pulses to the counter.
- `ballot_ready` output, 1 bit: panel armed (voter LED).
- `vote_done` output, 1 bit: one-cycle pulse when a vote completes.
- `invalid_press` output, 1 bit: one-cycle pulse on a multi-button press.
- `votes_cast` output, 16 bits: number of completed votes; saturates at 16'hFFFF.

## Operation
- **Input synchronization:** each `btn_n` passes through a 2-flop synchronizer. `pat` is the 3-bit synchronized pattern.
- **States:** IDLE, ARMED, DEBOUNCE, PULSE, HOLDOFF, CLOSED.
- **IDLE:** `ballot_ready`=0.
  - If `ballot_issue`=1 and `pat`==0, go to ARMED.
  - If `ballot_issue`=1 while `pat`!=0, the issue is ignored and not queued.
- **ARMED:** `ballot_ready`=1.
  - `pat` one-hot: latch `sel`=`pat`; this cycle counts as sample 1.
    - If `DEBOUNCE_CYCLES`==1, go to PULSE.
    - Otherwise go to DEBOUNCE.
  - `pat` multi-hot: stay in ARMED.
- **DEBOUNCE:** `ballot_ready`=1.
  - Each cycle with `pat`==`sel` adds one sample. When the sample count reaches `DEBOUNCE_CYCLES`, go to PULSE.
  - Any cycle with `pat`!=`sel`: return to ARMED and clear the count.
- **`invalid_press`:** pulses for one cycle when `pat` becomes multi-hot, having been not multi-hot the previous cycle, while in ARMED or DEBOUNCE.
- **PULSE:** `candidate_<sel>`=1 for exactly `PULSE_CYCLES` cycles; the other two candidate lines stay 0. Then go to HOLDOFF.
- **HOLDOFF:** all candidate lines 0 for at least `HOLDOFF_CYCLES` cycles.
  - Exit only after the count is done and `pat`==0; a held button extends HOLDOFF indefinitely.
  - On exit: go to IDLE, pulse `vote_done` for one cycle, and increment `votes_cast` (saturating).
- **`voting_over`:** `voting_over`=1 in any state forces CLOSED at the next edge.
  - All candidate lines go to 0, `ballot_ready`=0, and the count is cleared.
  - An aborted vote does not increment `votes_cast`.
  - The unit stays in CLOSED while `voting_over`=1; when it is 0, go to IDLE.
  - `ballot_issue` is ignored in CLOSED.
- **Stray `ballot_issue`:** ignored in every state except IDLE.
- **Reset (`rst`=0, asynchronous, any state):**
  - State goes to IDLE; synchronizers and all counters clear.
  - All outputs go to 0, including `votes_cast`=0.
  - A pulse in flight is cut off immediately.

## Timing
- Let E be the first clock edge that samples `btn_n`=1 into synchronizer stage 1.
  - `pat` reflects the button after edge E+1.
  - `candidate_n` rises at edge E+`DEBOUNCE_CYCLES`+1 (default: E+9).
  - `candidate_n` falls at edge E+`DEBOUNCE_CYCLES`+1+`PULSE_CYCLES`.
- If the button was released before HOLDOFF expires, `vote_done`=1 and `ballot_ready` may be reasserted from the next issue, `HOLDOFF_CYCLES` edges after the falling edge.
- From IDLE, `ballot_issue`=1 sampled at edge T gives `ballot_ready`=1 after edge T.
- All outputs are registered; no combinational path from inputs to outputs.
- Button releases are seen 2 cycles late through the synchronizer.

## Test plan
- **Basic vote:**
  - Stimulus: defaults; issue ballot; hold `btn_2` for 20 clocks.
  - Required: `candidate_2` high for exactly 4 clocks starting at E+9; `vote_done` one pulse; `votes_cast`=1; `candidate_1` and `candidate_3` stay 0.
- **Bounce rejection:**
  - Stimulus: `btn_1` toggles with a period of 3 clocks for 30 clocks, then holds.
  - Required: no pulse during the toggling; exactly one pulse 9 clocks after a stable hold.
- **Multi-press:**
  - Stimulus: `btn_1` and `btn_3` rise together.
  - Required: `invalid_press` one pulse; no candidate pulse; releasing `btn_3` while still holding `btn_1` then yields a `candidate_1` pulse.
- **No ballot / held button:**
  - Stimulus 1: press without `ballot_issue`. Required: nothing happens.
  - Stimulus 2: keep `btn_1` held 100 clocks after the pulse. Required: HOLDOFF persists; `vote_done` comes 2 clocks after release plus the remaining hold-off.
- **Close mid-pulse:**
  - Stimulus: `voting_over`=1 during the 2nd PULSE cycle.
  - Required: candidate line 0 next clock; `votes_cast` unchanged; `ballot_issue` ignored until `voting_over`=0.
- **Async reset mid-HOLDOFF:**
  - Stimulus: `rst`=0 between clock edges during HOLDOFF.
  - Required: all outputs 0 immediately (`votes_cast`=0), state IDLE.
- **Saturation:**
  - Stimulus: force `votes_cast` to 16'hFFFF, then cast one more vote.
  - Required: `votes_cast` stays 16'hFFFF.
